reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
Write-back buffer directly upstream of the 16-entry register file. It accepts results from three producers: ALU, memory load unit, and the 32-bit stack-pointer unit. It queues them in a small FIFO and drives the register file write port (we/src_w/val) with at most one write per cycle. It also exports a per-register pending-write scoreboard so decode can stall on read-after-write hazards.

Parameters:
DEPTH, 4, total queued write capacity including the output stage; power of two, minimum 2.

Ports:
cpu_clk  input  1  CPU clock; all state updates on the rising edge.
cpu_rst_n  input  1  asynchronous active-low reset.
alu_valid  input  1  ALU result offered.
alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
alu_dst  input  4  ALU destination register index.
alu_val  input  16  ALU result.
mem_valid  input  1  load result offered.
mem_ready  output  1  load result accepted this cycle when mem_valid is also high.
mem_dst  input  4  load destination register index.
mem_val  input  16  load data.
sp_valid  input  1  32-bit stack-pointer update offered.
sp_ready  output  1  SP update accepted this cycle when sp_valid is also high.
sp_val  input  32  new SP; [15:0] goes to reg 14 (sp_low), [31:16] goes to reg 15 (sp_high).
we  output  1  register file write enable.
src_w  output  4  register file write index.
val  output  16  register file write data.
busy  output  16  bit r = a write to register r is queued or being presented.
count  output  clog2(DEPTH)+1  current occupancy, for debug and performance counters.

Behaviour:
- Reset (cpu_rst_n low, asynchronous): FIFO emptied, count=0, we=0, src_w=0, val=0, busy=0. All readies are held 0 while reset is asserted. Entries pending at reset are discarded and never written.
- Storage: each entry holds {dst[3:0], val[15:0]}. The FIFO head drives we/src_w/val directly from registered state.
  - we=1 exactly when count>0.
  - The register file consumes unconditionally, so the head pops every cycle that we=1.
- Acceptance: at most one producer transaction per cycle. Fixed priority is mem > sp > alu.
  - mem_ready = (count < DEPTH).
  - sp_ready = !mem_valid && (count <= DEPTH-2).
  - alu_ready = !mem_valid && !sp_valid && (count < DEPTH).
  - Each ready is combinational from count and the higher-priority valids only. No ready depends on its own valid.
- Occupancy uses the current count, ignoring the same-cycle pop. This is deliberately conservative so readies are never derived from we.
- SP update: one handshake pushes two entries in one cycle, {14, sp_val[15:0]} then {15, sp_val[31:16]}. These produce writes on two consecutive we cycles, low half first.
- Register 0: an accepted ALU or load transaction with dst=0 completes the handshake, but nothing is pushed and busy is unaffected.
- Latency: when the FIFO is empty, a transaction accepted at edge N presents we=1 in the cycle after N, and regs commits at edge N+1.
- Throughput: one write per cycle. The SP update costs two write cycles.
- Simultaneous push and pop:
  - count_next = count + pushed - popped, where pushed is 0, 1 or 2 and popped is 0 or 1.
  - The full condition is evaluated before the pop.
- Ordering: writes leave in strict acceptance order. The last accepted write to a register wins.
- Pointers: read and write pointers wrap modulo DEPTH. count distinguishes full from empty.
- busy:
  - busy[r] = OR over valid entries (head included) of (dst==r), recomputed combinationally from registered state.
  - busy[r] rises in the cycle after acceptance and falls in the cycle after the last write to r is presented.
  - busy[0] is always 0.
- Outputs when idle (count=0): we=0; src_w and val hold their last values. Consumers ignore src_w and val when we=0.
- No X propagation: val and src_w reset to 0.

Test Plan:
1. Reset then single ALU write {dst=3, val=16'h1234} -> alu_ready=1. Next cycle: we=1, src_w=3, val=16'h1234, busy=16'h0008. Following cycle: we=0, busy=0.
2. mem_valid, sp_valid and alu_valid all high in one cycle with count=0 -> only mem_ready=1. Next cycle sp_ready=1 if mem_valid drops. ALU is accepted only after both drop. Write order on src_w is mem_dst, 14, 15, alu_dst.
3. SP update sp_val=32'hDEAD_BEEF -> two consecutive cycles: we=1/src_w=14/val=16'hBEEF, then we=1/src_w=15/val=16'hDEAD. busy[15:14] rise together and clear one cycle apart.
4. DEPTH=4, hold alu_valid with distinct dst values every cycle -> count settles at 1 or 2 with no ready drop (push and pop balance). With count=3, sp_valid -> sp_ready=0 until count<=2, while alu_ready stays 1 when sp_valid=0.
5. ALU write with dst=0, val=16'hFFFF -> alu_ready=1, count stays 0, we never asserts, busy=0.
6. Queue 3 entries, then pull cpu_rst_n low mid-drain for one cycle -> we=0, count=0, busy=0 immediately (asynchronous), and none of the remaining entries are written after reset release.

Source files
------------

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - write-back queue in front of the 16-entry register file
//
// Queues results from three producers (mem > sp > alu priority) and drives one
// register file write per cycle. It also exports a pending-write scoreboard.
//
// Ports:
//   cpu_clk, cpu_rst_n          clock, asynchronous active-low reset
//   mem_valid/ready/dst/val     load result handshake (highest priority)
//   sp_valid/ready/val          32-bit SP update, writes reg 14 then reg 15
//   alu_valid/ready/dst/val     ALU result handshake (lowest priority)
//   we, src_w, val              register file write port, driven from the FIFO head
//   busy                        bit r set while a write to r is queued or presented
//   count                       current occupancy
module reg_writeback #(
   parameter int DEPTH = 4
) (
   input  logic                     cpu_clk,
   input  logic                     cpu_rst_n,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [3:0]               alu_dst,
   input  logic [15:0]              alu_val,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [3:0]               mem_dst,
   input  logic [15:0]              mem_val,
   input  logic                     sp_valid,
   output logic                     sp_ready,
   input  logic [31:0]              sp_val,
   output logic                     we,
   output logic [3:0]               src_w,
   output logic [15:0]              val,
   output logic [15:0]              busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
   localparam logic [CW-1:0] SP_MAX_C = CW'(DEPTH - 2);

   logic [19:0]   fifo_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    src_w_q, src_w_d;
   logic [15:0]   val_q, val_d;
   logic          mem_acc, sp_acc, alu_acc, pop;
   logic [1:0]    push_n;
   logic [19:0]   push0, push1;
   logic [15:0]   busy_c;

   // Readies look only at registered occupancy (not the same-cycle pop) and at
   // higher-priority valids, so none depends on its own valid or on we.
   assign mem_ready = cpu_rst_n && (count_q < FULL_C);
   assign sp_ready  = cpu_rst_n && !mem_valid && (count_q <= SP_MAX_C);
   assign alu_ready = cpu_rst_n && !mem_valid && !sp_valid && (count_q < FULL_C);

   assign mem_acc = mem_valid && mem_ready;
   assign sp_acc  = sp_valid && sp_ready;
   assign alu_acc = alu_valid && alu_ready;

   always_comb begin
      push_n = 2'd0;
      push0  = '0;
      push1  = '0;
      // Writes to register 0 complete the handshake but are dropped here.
      if (mem_acc) begin
         if (mem_dst != 4'd0) begin
            push_n = 2'd1;
            push0  = {mem_dst, mem_val};
         end
      end else if (sp_acc) begin
         push_n = 2'd2;
         push0  = {4'd14, sp_val[15:0]};
         push1  = {4'd15, sp_val[31:16]};
      end else if (alu_acc && (alu_dst != 4'd0)) begin
         push_n = 2'd1;
         push0  = {alu_dst, alu_val};
      end
   end

   always_comb begin
      pop      = (count_q != '0);
      count_d  = count_q + CW'(push_n) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push_n);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      src_w_d  = src_w_q;
      val_d    = val_q;
      // Preload the next head into the output registers: an entry already in
      // storage if one survives the pop, otherwise the first entry pushed now.
      // With nothing left the outputs keep their last values.
      if ((count_q - CW'(pop)) != '0) begin
         {src_w_d, val_d} = fifo_q[rd_ptr_d];
      end else if (push_n != 2'd0) begin
         {src_w_d, val_d} = push0;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (push_n != 2'd0) begin
         fifo_q[wr_ptr_q] <= push0;
      end
      if (push_n == 2'd2) begin
         fifo_q[wr_ptr_q + AW'(1)] <= push1;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         src_w_q  <= '0;
         val_q    <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         src_w_q  <= src_w_d;
         val_q    <= val_d;
      end
   end

   always_comb begin
      busy_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q) begin
            busy_c[fifo_q[rd_ptr_q + AW'(i)][19:16]] = 1'b1;
         end
      end
      busy = busy_c & 16'hFFFE;
   end

   assign we    = (count_q != '0);
   assign src_w = src_w_q;
   assign val   = val_q;
   assign count = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - self-checking bench for reg_writeback
module tb_reg_writeback;

   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH) + 1;

   logic          cpu_clk = 1'b0;
   logic          cpu_rst_n = 1'b0;
   logic          alu_valid = 1'b0, mem_valid = 1'b0, sp_valid = 1'b0;
   logic          alu_ready, mem_ready, sp_ready;
   logic [3:0]    alu_dst = '0, mem_dst = '0;
   logic [15:0]   alu_val = '0, mem_val = '0;
   logic [31:0]   sp_val = '0;
   logic          we;
   logic [3:0]    src_w;
   logic [15:0]   val;
   logic [15:0]   busy;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of pending {dst, val} writes plus held output values.
   logic [19:0] mq[$];
   logic [3:0]  m_src = '0;
   logic [15:0] m_val = '0;

   reg_writeback #(.DEPTH(DEPTH)) dut (
      .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_val(alu_val),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_val(mem_val),
      .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_val(sp_val),
      .we(we), .src_w(src_w), .val(val), .busy(busy), .count(count)
   );

   always #5 cpu_clk = ~cpu_clk;

   function automatic logic [15:0] m_busy();
      logic [15:0] b;
      b = '0;
      foreach (mq[i]) b[mq[i][19:16]] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   function automatic logic e_mem_rdy();
      return mq.size() < DEPTH;
   endfunction

   function automatic logic e_sp_rdy();
      return !mem_valid && (mq.size() <= DEPTH - 2);
   endfunction

   function automatic logic e_alu_rdy();
      return !mem_valid && !sp_valid && (mq.size() < DEPTH);
   endfunction

   task automatic idle();
      mem_valid = 1'b0; sp_valid = 1'b0; alu_valid = 1'b0;
   endtask

   // One clock edge: apply the acceptance rules to the model, then settle #1.
   task automatic tick();
      bit am, asp, aa;
      am  = mem_valid && e_mem_rdy();
      asp = sp_valid && e_sp_rdy();
      aa  = alu_valid && e_alu_rdy();
      @(posedge cpu_clk);
      if (mq.size() > 0) mq.delete(0);
      if (am) begin
         if (mem_dst != 4'd0) mq.push_back({mem_dst, mem_val});
      end else if (asp) begin
         mq.push_back({4'd14, sp_val[15:0]});
         mq.push_back({4'd15, sp_val[31:16]});
      end else if (aa && alu_dst != 4'd0) begin
         mq.push_back({alu_dst, alu_val});
      end
      if (mq.size() > 0) begin
         m_src = mq[0][19:16];
         m_val = mq[0][15:0];
      end
      #1;
   endtask

   task automatic drain(input int n);
      idle();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      mem_valid = 1'b1; sp_valid = 1'b1; alu_valid = 1'b1;
      #1;
      checks++; if ({mem_ready, sp_ready, alu_ready} !== 3'b000) begin errors++; $display("FAIL reset_readies: got %b expected 000", {mem_ready, sp_ready, alu_ready}); end
      checks++; if (we !== 1'b0 || count !== '0) begin errors++; $display("FAIL reset_we_count: got we=%b count=%0d expected 0/0", we, count); end
      checks++; if (src_w !== 4'd0 || val !== 16'd0 || busy !== 16'd0) begin errors++; $display("FAIL reset_outs: got src_w=%0h val=%0h busy=%0h expected 0", src_w, val, busy); end
      idle();
      @(posedge cpu_clk); #1;
      cpu_rst_n = 1'b1;
      mq.delete(); m_src = '0; m_val = '0;
   endtask

   task automatic test_single_alu();
      alu_valid = 1'b1; alu_dst = 4'd3; alu_val = 16'h1234;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", alu_ready); end
      tick();
      idle();
      checks++; if (we !== 1'b1 || src_w !== 4'd3 || val !== 16'h1234) begin errors++; $display("FAIL single_write: got we=%b src_w=%0d val=%h expected 1/3/1234", we, src_w, val); end
      checks++; if (busy !== 16'h0008 || count !== CW'(1)) begin errors++; $display("FAIL single_busy: got busy=%h count=%0d expected 0008/1", busy, count); end
      tick();
      checks++; if (we !== 1'b0 || busy !== 16'h0000 || count !== '0) begin errors++; $display("FAIL single_idle: got we=%b busy=%h count=%0d expected 0/0000/0", we, busy, count); end
      checks++; if (src_w !== 4'd3 || val !== 16'h1234) begin errors++; $display("FAIL single_hold: got src_w=%0d val=%h expected 3/1234", src_w, val); end
   endtask

   task automatic test_priority();
      logic [3:0] obs[$];
      logic [3:0] expv[4];
      expv[0] = 4'd5; expv[1] = 4'd14; expv[2] = 4'd15; expv[3] = 4'd9;
      mem_valid = 1'b1; mem_dst = 4'd5; mem_val = 16'h0505;
      sp_valid = 1'b1; sp_val = 32'h2222_1111;
      alu_valid = 1'b1; alu_dst = 4'd9; alu_val = 16'h0909;
      #1;
      checks++; if ({mem_ready, sp_ready, alu_ready} !== 3'b100) begin errors++; $display("FAIL prio_all: got %b expected 100", {mem_ready, sp_ready, alu_ready}); end
      tick(); if (we) obs.push_back(src_w);
      mem_valid = 1'b0;
      #1;
      checks++; if ({sp_ready, alu_ready} !== 2'b10) begin errors++; $display("FAIL prio_sp: got %b expected 10", {sp_ready, alu_ready}); end
      tick(); if (we) obs.push_back(src_w);
      sp_valid = 1'b0;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu: got %b expected 1", alu_ready); end
      tick(); if (we) obs.push_back(src_w);
      idle();
      for (int i = 0; i < 6; i++) begin tick(); if (we) obs.push_back(src_w); end
      checks++;
      if (obs.size() != 4) begin
         errors++; $display("FAIL prio_order_len: got %0d writes expected 4", obs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (obs[i] !== expv[i]) begin errors++; $display("FAIL prio_order[%0d]: got %0d expected %0d", i, obs[i], expv[i]); end
         end
      end
   endtask

   task automatic test_sp();
      sp_valid = 1'b1; sp_val = 32'hDEAD_BEEF;
      #1;
      checks++; if (sp_ready !== 1'b1) begin errors++; $display("FAIL sp_ready: got %b expected 1", sp_ready); end
      tick();
      idle();
      checks++; if (we !== 1'b1 || src_w !== 4'd14 || val !== 16'hBEEF || busy !== 16'hC000) begin errors++; $display("FAIL sp_low: got we=%b src_w=%0d val=%h busy=%h expected 1/14/beef/c000", we, src_w, val, busy); end
      tick();
      checks++; if (we !== 1'b1 || src_w !== 4'd15 || val !== 16'hDEAD || busy !== 16'h8000) begin errors++; $display("FAIL sp_high: got we=%b src_w=%0d val=%h busy=%h expected 1/15/dead/8000", we, src_w, val, busy); end
      tick();
      checks++; if (we !== 1'b0 || busy !== 16'h0000) begin errors++; $display("FAIL sp_done: got we=%b busy=%h expected 0/0000", we, busy); end
   endtask

   task automatic test_stream_and_full();
      for (int k = 1; k <= 8; k++) begin
         alu_valid = 1'b1; alu_dst = 4'(k); alu_val = 16'($urandom);
         #1;
         checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, alu_ready); end
         tick();
         checks++; if (count < CW'(1) || count > CW'(2) || count !== CW'(mq.size())) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected %0d", k, count, mq.size()); end
      end
      drain(3);
      sp_valid = 1'b1; sp_val = 32'h0102_0304;
      tick();
      sp_val = 32'h0506_0708;
      #1;
      checks++; if (sp_ready !== 1'b1) begin errors++; $display("FAIL full_sp_at2: got %b expected 1", sp_ready); end
      tick();
      checks++; if (count !== CW'(3)) begin errors++; $display("FAIL full_count3: got %0d expected 3", count); end
      sp_valid = 1'b0; alu_valid = 1'b1; alu_dst = 4'd7;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL full_alu_at3: got %b expected 1", alu_ready); end
      alu_valid = 1'b0; sp_valid = 1'b1; sp_val = 32'hAAAA_5555;
      #1;
      checks++; if (sp_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL full_sp_at3: got sp=%b mem=%b expected 0/1", sp_ready, mem_ready); end
      tick();
      checks++; if (sp_ready !== 1'b1 || count !== CW'(2)) begin errors++; $display("FAIL full_sp_at2b: got sp=%b count=%0d expected 1/2", sp_ready, count); end
      tick();
      checks++; if (count !== CW'(mq.size()) || busy !== m_busy()) begin errors++; $display("FAIL full_after: got count=%0d busy=%h expected %0d/%h", count, busy, mq.size(), m_busy()); end
      drain(5);
   endtask

   task automatic test_reg0();
      alu_valid = 1'b1; alu_dst = 4'd0; alu_val = 16'hFFFF;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reg0_ready: got %b expected 1", alu_ready); end
      tick();
      idle();
      checks++; if (count !== '0 || we !== 1'b0 || busy !== 16'h0) begin errors++; $display("FAIL reg0_alu: got count=%0d we=%b busy=%h expected 0/0/0", count, we, busy); end
      mem_valid = 1'b1; mem_dst = 4'd0; mem_val = 16'hFFFF;
      tick();
      idle();
      tick();
      checks++; if (count !== '0 || we !== 1'b0 || busy !== 16'h0) begin errors++; $display("FAIL reg0_mem: got count=%0d we=%b busy=%h expected 0/0/0", count, we, busy); end
   endtask

   task automatic test_reset_mid();
      int wr;
      sp_valid = 1'b1; sp_val = 32'h1111_2222;
      tick();
      sp_val = 32'h3333_4444;
      tick();
      idle();
      checks++; if (count !== CW'(3)) begin errors++; $display("FAIL rstmid_fill: got %0d expected 3", count); end
      #2;
      cpu_rst_n = 1'b0;
      #1;
      checks++; if (we !== 1'b0 || count !== '0 || busy !== 16'h0 || src_w !== 4'd0 || val !== 16'd0) begin errors++; $display("FAIL rstmid_async: got we=%b count=%0d busy=%h src_w=%0d val=%h expected all 0", we, count, busy, src_w, val); end
      @(posedge cpu_clk); #1;
      cpu_rst_n = 1'b1;
      mq.delete(); m_src = '0; m_val = '0;
      wr = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (we) wr++; end
      checks++; if (wr != 0) begin errors++; $display("FAIL rstmid_discard: got %0d writes expected 0", wr); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         mem_valid = ($urandom_range(0, 3) == 0);
         sp_valid  = ($urandom_range(0, 4) == 0);
         alu_valid = ($urandom_range(0, 1) == 0);
         mem_dst = 4'($urandom_range(0, 15)); mem_val = 16'($urandom);
         alu_dst = 4'($urandom_range(0, 15)); alu_val = 16'($urandom);
         sp_val = $urandom;
         #1;
         checks++; if ({mem_ready, sp_ready, alu_ready} !== {e_mem_rdy(), e_sp_rdy(), e_alu_rdy()}) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, {mem_ready, sp_ready, alu_ready}, {e_mem_rdy(), e_sp_rdy(), e_alu_rdy()}); end
         tick();
         checks++; if (we !== (mq.size() != 0) || count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_occ[%0d]: got we=%b count=%0d expected count %0d", c, we, count, mq.size()); end
         checks++; if (src_w !== m_src || val !== m_val) begin errors++; $display("FAIL rnd_head[%0d]: got %0d/%h expected %0d/%h", c, src_w, val, m_src, m_val); end
         checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rnd_busy[%0d]: got %h expected %h", c, busy, m_busy()); end
      end
      drain(6);
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_priority();
      test_sp();
      test_stream_and_full();
      test_reg0();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
